alu_wb_master: RTL and testbench

//  Wishbone pipelined-mode bus master (initiator) that drives the 8-bit ALU slave.

---
 rtl/alu_wb_master.sv | 172 +++++++++++++++++
 tb/tb_alu_wb_master.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_master.sv
// alu_wb_master: Wishbone pipelined-mode initiator that runs one ALU command as
// write A, write B, read result, read flags, and returns result/flags/err.
module alu_wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter logic [7:0]  ADDR_A         = 8'h00,
    parameter logic [7:0]  ADDR_B         = 8'h01,
    parameter logic [7:0]  ADDR_FLAGS     = 8'h02
) (
    input  logic       i_clk,
    input  logic       reset_n,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [7:0] i_cmd_op,
    input  logic [7:0] i_cmd_a,
    input  logic [7:0] i_cmd_b,
    output logic       o_res_valid,
    output logic [7:0] o_res_data,
    output logic [7:0] o_res_flags,
    output logic       o_res_err,
    output logic       o_wb_cyc,
    output logic       o_wb_stb,
    output logic       o_wb_we,
    output logic [7:0] o_wb_addr,
    output logic [7:0] o_wb_data,
    input  logic       i_wb_ack,
    input  logic       i_wb_stall,
    input  logic [7:0] i_wb_data
);
    localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_MAX  = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    typedef enum logic [1:0] {PH_WR_A, PH_WR_B, PH_RD_OP, PH_RD_FL} phase_t;

    typedef struct packed {
        logic [7:0] addr;
        logic       we;
        logic [7:0] data;
    } wb_req_t;

    state_t        state;
    phase_t        phase;
    logic [CW-1:0] tmo_cnt;
    logic [CW-1:0] tmo_inc;
    logic          tmo_hit;
    logic [7:0]    a_q, b_q, op_q;

    function automatic wb_req_t phase_req(phase_t ph, logic [7:0] a, logic [7:0] b,
                                          logic [7:0] op);
        wb_req_t r;
        case (ph)
            PH_WR_A:  r = '{addr: ADDR_A, we: 1'b1, data: a};
            PH_WR_B:  r = '{addr: ADDR_B, we: 1'b1, data: b};
            PH_RD_OP: r = '{addr: op, we: 1'b0, data: 8'h00};
            default:  r = '{addr: ADDR_FLAGS, we: 1'b0, data: 8'h00};
        endcase
        return r;
    endfunction

    function automatic phase_t next_phase(phase_t ph);
        case (ph)
            PH_WR_A:  return PH_WR_B;
            PH_WR_B:  return PH_RD_OP;
            default:  return PH_RD_FL;
        endcase
    endfunction

    // Abort fires on the edge that closes the TIMEOUT_CYCLES-th cycle in a phase
    assign tmo_hit = (tmo_cnt >= TMO_LAST);
    assign tmo_inc = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + 1'b1;

    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            phase       <= PH_WR_A;
            tmo_cnt     <= '0;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            op_q        <= 8'h00;
            o_cmd_ready <= 1'b1;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_addr   <= 8'h00;
            o_wb_data   <= 8'h00;
            o_res_valid <= 1'b0;
            o_res_data  <= 8'h00;
            o_res_flags <= 8'h00;
            o_res_err   <= 1'b0;
        end else begin
            o_res_valid <= 1'b0;
            o_res_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_cmd_valid && o_cmd_ready) begin
                        a_q         <= i_cmd_a;
                        b_q         <= i_cmd_b;
                        op_q        <= i_cmd_op;
                        phase       <= PH_WR_A;
                        state       <= S_REQ;
                        tmo_cnt     <= '0;
                        o_cmd_ready <= 1'b0;
                        o_wb_cyc    <= 1'b1;
                        o_wb_stb    <= 1'b1;
                        {o_wb_addr, o_wb_we, o_wb_data} <=
                            phase_req(PH_WR_A, i_cmd_a, i_cmd_b, i_cmd_op);
                    end
                end
                S_REQ: begin
                    if (tmo_hit) begin
                        state       <= S_IDLE;
                        o_cmd_ready <= 1'b1;
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        o_wb_we     <= 1'b0;
                        o_wb_addr   <= 8'h00;
                        o_wb_data   <= 8'h00;
                        o_res_valid <= 1'b1;
                        o_res_err   <= 1'b1;
                        o_res_data  <= 8'h00;
                        o_res_flags <= 8'h00;
                    end else begin
                        tmo_cnt <= tmo_inc;
                        if (!i_wb_stall) begin
                            o_wb_stb <= 1'b0;
                            o_wb_we  <= 1'b0;
                            state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (i_wb_ack) begin
                        tmo_cnt <= '0;
                        if (phase == PH_RD_OP)
                            o_res_data <= i_wb_data;
                        if (phase == PH_RD_FL) begin
                            o_res_flags <= i_wb_data;
                            state       <= S_IDLE;
                            o_cmd_ready <= 1'b1;
                            o_wb_cyc    <= 1'b0;
                            o_wb_addr   <= 8'h00;
                            o_wb_data   <= 8'h00;
                            o_res_valid <= 1'b1;
                        end else begin
                            phase    <= next_phase(phase);
                            state    <= S_REQ;
                            o_wb_stb <= 1'b1;
                            {o_wb_addr, o_wb_we, o_wb_data} <=
                                phase_req(next_phase(phase), a_q, b_q, op_q);
                        end
                    end else if (tmo_hit) begin
                        state       <= S_IDLE;
                        o_cmd_ready <= 1'b1;
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        o_wb_we     <= 1'b0;
                        o_wb_addr   <= 8'h00;
                        o_wb_data   <= 8'h00;
                        o_res_valid <= 1'b1;
                        o_res_err   <= 1'b1;
                        o_res_data  <= 8'h00;
                        o_res_flags <= 8'h00;
                    end else begin
                        tmo_cnt <= tmo_inc;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_wb_master.sv
// tb_alu_wb_master: drives alu_wb_master against a behavioural Wishbone ALU slave
// and checks responses, latency and bus traffic against an arithmetic model.
module tb_alu_wb_master;
    logic       i_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       i_cmd_valid = 1'b0;
    logic       o_cmd_ready;
    logic [7:0] i_cmd_op = 8'h00;
    logic [7:0] i_cmd_a = 8'h00;
    logic [7:0] i_cmd_b = 8'h00;
    logic       o_res_valid;
    logic [7:0] o_res_data;
    logic [7:0] o_res_flags;
    logic       o_res_err;
    logic       o_wb_cyc;
    logic       o_wb_stb;
    logic       o_wb_we;
    logic [7:0] o_wb_addr;
    logic [7:0] o_wb_data;
    logic       i_wb_ack;
    logic       i_wb_stall = 1'b0;
    logic [7:0] i_wb_data = 8'h00;

    alu_wb_master dut (
        .i_clk(i_clk), .reset_n(reset_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_op(i_cmd_op), .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b),
        .o_res_valid(o_res_valid), .o_res_data(o_res_data),
        .o_res_flags(o_res_flags), .o_res_err(o_res_err),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n = 0;
    always @(posedge i_clk) edge_n <= edge_n + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Slave configuration, written only by the main sequence
    logic       sl_ack = 1'b0;
    logic       stray_ack = 1'b0;
    logic       stray_req_en = 1'b0;
    logic       noack_en = 1'b0;
    logic [7:0] noack_addr = 8'h00;
    logic [7:0] stall_addr = 8'h00;
    int         stall_n = 0;
    assign i_wb_ack = sl_ack | stray_ack;

    typedef struct { logic [7:0] addr; logic we; logic [7:0] data; } txn_t;
    txn_t       log_q[$];
    int         stall_done = 0;
    logic       have_snap = 1'b0;
    logic [8:0] snap = '0;
    logic       ack_pend = 1'b0;
    logic [7:0] ack_data = 8'h00;
    logic [7:0] sl_a = 8'h00, sl_b = 8'h00, sl_fl = 8'h00, rd = 8'h00;
    logic [8:0] t = '0;

    // Slave: decides stall/ack at negedge for the following rising edge; ack one cycle after acceptance
    always @(negedge i_clk) begin
        sl_ack     = 1'b0;
        i_wb_stall = 1'b0;
        if (!reset_n) begin
            ack_pend = 1'b0;
        end else begin
            if (ack_pend) begin
                sl_ack    = 1'b1;
                i_wb_data = ack_data;
                ack_pend  = 1'b0;
            end
            if (i_cmd_valid && o_cmd_ready) begin
                stall_done = 0;
                have_snap  = 1'b0;
                log_q.delete();
            end
            if (o_wb_cyc && o_wb_stb) begin
                if (stall_done < stall_n && o_wb_addr == stall_addr) begin
                    i_wb_stall = 1'b1;
                    stall_done++;
                    if (have_snap) chk("stall hold we/data", {23'd0, o_wb_we, o_wb_data}, {23'd0, snap});
                    else begin snap = {o_wb_we, o_wb_data}; have_snap = 1'b1; end
                end else begin
                    if (stray_req_en && o_wb_we && o_wb_addr == 8'h00) sl_ack = 1'b1;
                    log_q.push_back('{o_wb_addr, o_wb_we, o_wb_data});
                    rd = 8'h00;
                    if (o_wb_we) begin
                        if (o_wb_addr == 8'h00) sl_a = o_wb_data;
                        else if (o_wb_addr == 8'h01) sl_b = o_wb_data;
                    end else begin
                        case (o_wb_addr)
                            8'h80: begin t = {1'b0, sl_a} + {1'b0, sl_b}; rd = t[7:0];
                                         sl_fl = {6'd0, t[7:0] == 8'h00, t[8]}; end
                            8'h81: begin t = {1'b0, sl_a} - {1'b0, sl_b}; rd = t[7:0];
                                         sl_fl = {6'd0, t[7:0] == 8'h00, t[8]}; end
                            8'h02: rd = sl_fl;
                            default: rd = 8'hEE;
                        endcase
                    end
                    if (!(noack_en && o_wb_addr == noack_addr)) begin
                        ack_pend = 1'b1;
                        ack_data = rd;
                    end
                end
            end
        end
    end

    typedef struct { logic [7:0] d; logic [7:0] f; logic e; logic cyc; logic rdy; int at; } res_t;
    res_t resq[$];
    always @(negedge i_clk)
        if (o_res_valid) resq.push_back('{o_res_data, o_res_flags, o_res_err, o_wb_cyc, o_cmd_ready, edge_n});

    // Reference: result = A op B modulo 256; flags bit1 = zero, bit0 = carry out / borrow
    function automatic void model(input logic [7:0] a, b, op, output logic [7:0] d, f);
        int r;
        if (op == 8'h81) r = int'(a) - int'(b);
        else             r = int'(a) + int'(b);
        d = 8'((r + 256) % 256);
        f = {6'd0, ((r + 256) % 256) == 0, (r < 0) || (r > 255)};
    endfunction

    task automatic send(input logic [7:0] a, b, op, output int acc);
        int n = 0;
        i_cmd_valid = 1'b1; i_cmd_a = a; i_cmd_b = b; i_cmd_op = op;
        while (!o_cmd_ready && n < 200) begin @(negedge i_clk); n++; end
        if (!o_cmd_ready) begin
            n_checks++; n_errors++;
            $display("FAIL cmd_ready never rose: got 0 expected 1");
        end
        acc = edge_n + 1;
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        i_cmd_a = 8'($urandom); i_cmd_b = 8'($urandom); i_cmd_op = 8'($urandom);
    endtask

    task automatic wait_res(input string nm, input logic [7:0] ed, ef, input logic ee,
                            input int acc, input int lat);
        res_t r;
        int n = 0;
        while (resq.size() == 0 && n < 100) begin @(negedge i_clk); n++; end
        if (resq.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL %s no response: got none expected one pulse", nm);
            return;
        end
        r = resq.pop_front();
        chk({nm, " data"}, {24'd0, r.d}, {24'd0, ed});
        chk({nm, " flags"}, {24'd0, r.f}, {24'd0, ef});
        chk({nm, " err"}, {31'd0, r.e}, {31'd0, ee});
        chk({nm, " cyc in pulse"}, {31'd0, r.cyc}, 32'd0);
        chk({nm, " ready in pulse"}, {31'd0, r.rdy}, 32'd1);
        if (lat >= 0) chk({nm, " latency"}, r.at - acc, lat);
    endtask

    task automatic run_cmd(input string nm, input logic [7:0] a, b, op, sa, input int sn,
                           input logic [7:0] ed, ef, input int lat);
        int acc;
        stall_addr = sa; stall_n = sn;
        send(a, b, op, acc);
        wait_res(nm, ed, ef, 1'b0, acc, lat);
        chk({nm, " txn count"}, log_q.size(), 4);
        if (log_q.size() == 4) begin
            chk({nm, " txn0"}, {15'd0, log_q[0].addr, log_q[0].we, log_q[0].data}, {15'd0, 8'h00, 1'b1, a});
            chk({nm, " txn1"}, {15'd0, log_q[1].addr, log_q[1].we, log_q[1].data}, {15'd0, 8'h01, 1'b1, b});
            chk({nm, " txn2"}, {15'd0, log_q[2].addr, log_q[2].we, log_q[2].data}, {15'd0, op, 1'b0, 8'h00});
            chk({nm, " txn3"}, {15'd0, log_q[3].addr, log_q[3].we, log_q[3].data}, {15'd0, 8'h02, 1'b0, 8'h00});
        end
        stall_n = 0;
    endtask

    typedef struct {
        logic [7:0] a, b, op, sa; int sn; logic [7:0] ed, ef; int lat;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int acc, acc2, n;
        logic [7:0] ed, ef, a, b, op, sa;
        int sn;

        vecs[0] = '{8'h05, 8'h03, 8'h80, 8'h00, 0, 8'h08, 8'h00, 8};
        vecs[1] = '{8'h05, 8'h03, 8'h80, 8'h01, 3, 8'h08, 8'h00, 11};
        vecs[2] = '{8'hFF, 8'h01, 8'h80, 8'h00, 0, 8'h00, 8'h03, 8};
        vecs[3] = '{8'h10, 8'h20, 8'h81, 8'h00, 0, 8'hF0, 8'h01, 8};
        vecs[4] = '{8'h20, 8'h20, 8'h81, 8'h02, 2, 8'h00, 8'h02, 10};
        vecs[5] = '{8'h7F, 8'h01, 8'h80, 8'h80, 1, 8'h80, 8'h00, 9};

        repeat (3) @(negedge i_clk);
        chk("reset cyc/stb/we", {29'd0, o_wb_cyc, o_wb_stb, o_wb_we}, 32'd0);
        chk("reset addr/data", {16'd0, o_wb_addr, o_wb_data}, 32'd0);
        chk("reset res", {14'd0, o_res_valid, o_res_err, o_res_data, o_res_flags}, 32'd0);
        reset_n = 1'b1;
        @(negedge i_clk);
        chk("ready after reset", {31'd0, o_cmd_ready}, 32'd1);

        for (int i = 0; i < 6; i++)
            run_cmd($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sa,
                    vecs[i].sn, vecs[i].ed, vecs[i].ef, vecs[i].lat);

        // Slave never acks the result read: abort 15 cycles after that phase starts
        noack_en = 1'b1; noack_addr = 8'h80;
        send(8'h05, 8'h03, 8'h80, acc);
        wait_res("timeout", 8'h00, 8'h00, 1'b1, acc, 19);
        noack_en = 1'b0;
        run_cmd("after timeout", 8'h05, 8'h03, 8'h80, 8'h00, 0, 8'h08, 8'h00, 8);

        // Second command held on the bus while busy; taken on the edge ending the pulse
        i_cmd_valid = 1'b1; i_cmd_a = 8'h05; i_cmd_b = 8'h03; i_cmd_op = 8'h80;
        n = 0;
        while (!o_cmd_ready && n < 50) begin @(negedge i_clk); n++; end
        acc = edge_n + 1;
        @(negedge i_clk);
        chk("b2b ready low busy", {31'd0, o_cmd_ready}, 32'd0);
        i_cmd_a = 8'hFF; i_cmd_b = 8'h01;
        n = 0;
        while (!o_cmd_ready && n < 50) begin @(negedge i_clk); n++; end
        acc2 = edge_n + 1;
        chk("b2b second accept edge", acc2 - acc, 9);
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        wait_res("b2b first", 8'h08, 8'h00, 1'b0, acc, 8);
        wait_res("b2b second", 8'h00, 8'h03, 1'b0, acc2, 8);

        // Reset while waiting on the result-read ack
        noack_en = 1'b1; noack_addr = 8'h80;
        send(8'h05, 8'h03, 8'h80, acc);
        n = 0;
        while (edge_n < acc + 6 && n < 20) begin @(negedge i_clk); n++; end
        chk("pre-reset cyc high", {31'd0, o_wb_cyc}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("reset drop cyc/stb/valid", {29'd0, o_wb_cyc, o_wb_stb, o_res_valid}, 32'd0);
        noack_en = 1'b0;
        @(negedge i_clk); @(negedge i_clk);
        reset_n = 1'b1;
        @(negedge i_clk);
        chk("ready after mid reset", {31'd0, o_cmd_ready}, 32'd1);
        chk("no pulse across reset", resq.size(), 0);
        run_cmd("after reset", 8'hFF, 8'h01, 8'h80, 8'h00, 0, 8'h00, 8'h03, 8);

        // Stray acks in IDLE and on the acceptance edge of the first request
        stray_ack = 1'b1;
        @(negedge i_clk);
        stray_ack = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("stray idle no pulse", resq.size(), 0);
        chk("stray idle state", {30'd0, o_wb_cyc, o_cmd_ready}, 32'd1);
        stray_req_en = 1'b1;
        run_cmd("stray req", 8'h05, 8'h03, 8'h80, 8'h00, 0, 8'h08, 8'h00, 8);
        stray_req_en = 1'b0;

        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            op = ($urandom_range(0, 1) == 0) ? 8'h80 : 8'h81;
            case ($urandom_range(0, 3))
                0: sa = 8'h00;
                1: sa = 8'h01;
                2: sa = op;
                default: sa = 8'h02;
            endcase
            sn = int'($urandom_range(0, 3));
            model(a, b, op, ed, ef);
            run_cmd($sformatf("rand%0d", i), a, b, op, sa, sn, ed, ef, 8 + sn);
        end

        repeat (3) @(negedge i_clk);
        chk("no extra pulses", resq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
